// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared SIMD vector constants and the lane unpacker state type
//
// Purpose: defaults for the vector word and lane widths, which the vector FIFO
//          also uses, plus the unpacker FSM state encoding.
// Ports:   none (package)
package simd_pkg;

  localparam int SIMD_WIDTH  = 248;
  localparam int SIMD_LANE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } vec_unpacker_state_t;

endpackage

// File: rtl/vec_unpacker.sv
// rtl/vec_unpacker.sv - splits vector FIFO words into a stream of lanes
//
// Purpose: pops one WIDTH-bit word from a show-ahead FIFO and presents it as
//          LANES = WIDTH/LANE_W lanes, lane 0 first (LSBs), one per handshake.
//          The next word is popped on the last lane's handshake, so consecutive
//          words stream with no bubble.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   o_fifo_read         - pop strobe to the vector FIFO
//   i_fifo_data         - FIFO head word, valid while i_fifo_empty=0
//   i_fifo_empty        - FIFO empty flag
//   o_valid, i_ready    - lane handshake
//   o_lane_data         - current lane
//   o_lane_idx          - index of the current lane
//   o_last              - current lane is lane LANES-1
//   o_busy              - a word is held (state is SHIFT)
//   o_word_count        - words popped, saturating (VEC_UNPACKER_STATS_EN only)
// Options: define VEC_UNPACKER_STATS_EN to add the o_word_count statistics port.
module vec_unpacker
  import simd_pkg::*;
#(
  parameter int WIDTH  = SIMD_WIDTH,
  parameter int LANE_W = SIMD_LANE_W,
  parameter int LANES  = WIDTH / LANE_W,
  parameter int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_fifo_read,
  input  logic [WIDTH-1:0]  i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [LANE_W-1:0] o_lane_data,
  output logic [IDX_W-1:0]  o_lane_idx,
  output logic              o_last,
`ifdef VEC_UNPACKER_STATS_EN
  output logic [15:0]       o_word_count,
`endif
  output logic              o_busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  vec_unpacker_state_t state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic                pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_fifo_empty) begin
          pop     = 1'b1;
          word_d  = i_fifo_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            // Index only ever wraps here, so codes above LAST_IDX stay unused.
            idx_d = '0;
            if (!i_fifo_empty) begin
              pop    = 1'b1;
              word_d = i_fifo_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over any pop the FSM would otherwise request this cycle.
  assign o_fifo_read = pop & ~rst;

  assign o_valid     = (state_q == SHIFT);
  assign o_busy      = (state_q == SHIFT);
  assign o_lane_data = word_q[idx_q*LANE_W +: LANE_W];
  assign o_lane_idx  = idx_q;
  assign o_last      = (state_q == SHIFT) && (idx_q == LAST_IDX);

`ifdef VEC_UNPACKER_STATS_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q <= '0;
    end else if (o_fifo_read && (word_count_q != 16'hFFFF)) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign o_word_count = word_count_q;
`endif

endmodule
